// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and sizes for the register-file write-port arbiter and its tag FIFO.
package rf_wb_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int XLEN_DEF   = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef struct packed {
      logic                we;
      reg_addr_t           wa;
      logic [XLEN_DEF-1:0] wd;
   } rf_wr_t;

endpackage

// File: rtl/ld_tag_fifo.sv
// In-order FIFO of load destination tags; exposes its storage and valid mask
// so the owner can search for duplicate destinations behind the head.
module ld_tag_fifo
   import rf_wb_arbiter_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  reg_addr_t             i_tag,
   output reg_addr_t             o_head,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [CNT_W-1:0]      o_count,
   output logic [PTR_W-1:0]      o_rd_ptr,
   output reg_addr_t [DEPTH-1:0] o_entries,
   output logic [DEPTH-1:0]      o_valid
);

   reg_addr_t [DEPTH-1:0] r_mem;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_tag;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
      end
   end

   // An entry is live when its distance from the read pointer is below the count.
   always_comb begin
      o_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         o_valid[i] = ({1'b0, PTR_W'(PTR_W'(i) - r_rd_ptr)} < r_count);
      end
   end

   assign o_head    = r_mem[r_rd_ptr];
   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rd_ptr  = r_rd_ptr;
   assign o_entries = r_mem;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between ALU writeback and load returns,
// tracks outstanding load destinations, and reports decode read hazards.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int LD_DEPTH = 4,
   parameter int XLEN     = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_alu_valid,
   input  reg_addr_t       i_alu_wa,
   input  logic [XLEN-1:0] i_alu_wd,
   output logic            o_alu_ready,
   input  logic            i_ld_issue,
   input  reg_addr_t       i_ld_issue_rd,
   output logic            o_ld_issue_ready,
   input  logic            i_ld_valid,
   input  logic [XLEN-1:0] i_ld_wd,
   input  reg_addr_t       i_ra1,
   input  reg_addr_t       i_ra2,
   output logic            o_hazard,
   output logic            o_rf_we,
   output reg_addr_t       o_rf_wa,
   output logic [XLEN-1:0] o_rf_wd,
   output logic            o_proto_err
);

   localparam int PTR_W = $clog2(LD_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [NUM_REGS-1:0]      r_pending;
   rf_wr_t                   r_hold;
   rf_wr_t                   r_out;
   logic                     r_proto_err;

   reg_addr_t                w_head;
   logic                     w_full;
   logic                     w_empty;
   logic [CNT_W-1:0]         w_count;
   logic [PTR_W-1:0]         w_rd_ptr;
   reg_addr_t [LD_DEPTH-1:0] w_entries;
   logic [LD_DEPTH-1:0]      w_valid;
   logic                     w_pop;
   logic                     w_push;
   logic                     w_head_dup;
   logic                     w_alu_ready;
   logic                     w_alu_acc;
   rf_wr_t                   w_sel;
   logic [NUM_REGS-1:0]      w_pending_nxt;

   ld_tag_fifo #(.DEPTH(LD_DEPTH)) u_tags (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_push),
      .i_pop     (w_pop),
      .i_tag     (i_ld_issue_rd),
      .o_head    (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_count   (w_count),
      .o_rd_ptr  (w_rd_ptr),
      .o_entries (w_entries),
      .o_valid   (w_valid)
   );

   // A push alongside a pop is taken even when full, so occupancy holds steady.
   assign w_pop       = i_ld_valid && !w_empty;
   assign w_push      = i_ld_issue && (!w_full || w_pop);
   assign w_alu_ready = !r_hold.we && !((i_alu_wa != '0) && r_pending[i_alu_wa]);
   assign w_alu_acc   = i_alu_valid && w_alu_ready;

   always_comb begin
      w_head_dup = 1'b0;
      for (int i = 0; i < LD_DEPTH; i++) begin
         if (w_valid[i] && (PTR_W'(i) != w_rd_ptr) && (w_entries[i] == w_head)) begin
            w_head_dup = 1'b1;
         end
      end
   end

   always_comb begin
      w_sel = '0;
      if (w_pop) begin
         w_sel = '{we: 1'b1, wa: w_head, wd: i_ld_wd};
      end else if (r_hold.we) begin
         w_sel = r_hold;
      end else if (w_alu_acc) begin
         w_sel = '{we: 1'b1, wa: i_alu_wa, wd: i_alu_wd};
      end
   end

   // The set is applied after the clear so a same-register push/pop stays pending.
   always_comb begin
      w_pending_nxt = r_pending;
      if (w_pop && !w_head_dup) begin
         w_pending_nxt[w_head] = 1'b0;
      end
      if (w_push && (i_ld_issue_rd != '0)) begin
         w_pending_nxt[i_ld_issue_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending   <= '0;
         r_hold      <= '0;
         r_out       <= '0;
         r_proto_err <= 1'b0;
      end else begin
         r_pending <= w_pending_nxt;
         r_out     <= '{we: w_sel.we && (w_sel.wa != '0), wa: w_sel.wa, wd: w_sel.wd};
         if (w_pop && w_alu_acc) begin
            r_hold <= '{we: 1'b1, wa: i_alu_wa, wd: i_alu_wd};
         end else if (!w_pop && r_hold.we) begin
            r_hold.we <= 1'b0;
         end
         if (i_ld_valid && w_empty) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   function automatic logic operand_busy(input reg_addr_t ra, input logic [NUM_REGS-1:0] pend,
                                         input rf_wr_t hold, input rf_wr_t out);
      return (ra != '0) && (pend[ra] || (hold.we && (hold.wa == ra)) || (out.we && (out.wa == ra)));
   endfunction

   assign o_hazard         = operand_busy(i_ra1, r_pending, r_hold, r_out) ||
                             operand_busy(i_ra2, r_pending, r_hold, r_out);
   assign o_alu_ready      = w_alu_ready;
   assign o_ld_issue_ready = !w_full;
   assign o_rf_we          = r_out.we;
   assign o_rf_wa          = r_out.wa;
   assign o_rf_wd          = r_out.wd;
   assign o_proto_err      = r_proto_err;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected register-file writes go into a
// scoreboard queue that a negedge monitor drains whenever the DUT writes.
module tb_rf_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_wa;
   logic [31:0] alu_wd;
   logic        alu_ready;
   logic        ld_issue;
   logic [4:0]  ld_issue_rd;
   logic        ld_issue_ready;
   logic        ld_valid;
   logic [31:0] ld_wd;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic        hazard;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic        proto_err;

   typedef struct {
      logic [4:0]  wa;
      logic [31:0] wd;
   } exp_t;

   exp_t expQ[$];
   int   vectors     = 0;
   int   miscompares = 0;

   rf_wb_arbiter #(.LD_DEPTH(4), .XLEN(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_alu_valid      (alu_valid),
      .i_alu_wa         (alu_wa),
      .i_alu_wd         (alu_wd),
      .o_alu_ready      (alu_ready),
      .i_ld_issue       (ld_issue),
      .i_ld_issue_rd    (ld_issue_rd),
      .o_ld_issue_ready (ld_issue_ready),
      .i_ld_valid       (ld_valid),
      .i_ld_wd          (ld_wd),
      .i_ra1            (ra1),
      .i_ra2            (ra2),
      .o_hazard         (hazard),
      .o_rf_we          (rf_we),
      .o_rf_wa          (rf_wa),
      .o_rf_wd          (rf_wd),
      .o_proto_err      (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic av, input logic [4:0] awa, input logic [31:0] awd,
                                input logic li, input logic [4:0] lrd,
                                input logic lv, input logic [31:0] lwd);
      alu_valid   = av;
      alu_wa      = awa;
      alu_wd      = awd;
      ld_issue    = li;
      ld_issue_rd = lrd;
      ld_valid    = lv;
      ld_wd       = lwd;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushExpected(input logic [4:0] wa, input logic [31:0] wd);
      exp_t e;
      e.wa = wa;
      e.wd = wd;
      expQ.push_back(e);
   endtask

   // Every committed write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && rf_we) begin
         if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpectedWrite: got x%0d=0x%0h, expected no write at %0t", rf_wa, rf_wd, $time);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("writeAddr", {27'd0, rf_wa}, {27'd0, e.wa});
            checkOutput("writeData", rf_wd, e.wd);
         end
      end
   end

   initial begin
      rst = 1'b1;
      ra1 = 5'd0;
      ra2 = 5'd0;
      idle();
      #12;
      checkOutput("resetWe", {31'd0, rf_we}, 32'd0);
      checkOutput("resetWa", {27'd0, rf_wa}, 32'd0);
      checkOutput("resetWd", rf_wd, 32'd0);
      checkOutput("resetProtoErr", {31'd0, proto_err}, 32'd0);
      checkOutput("resetIssueReady", {31'd0, ld_issue_ready}, 32'd1);
      checkOutput("resetAluReady", {31'd0, alu_ready}, 32'd1);
      rst = 1'b0;
      tick();

      // ALU-only write and the uncommitted-write hazard window
      applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 1'b0, 32'h0);
      ra1 = 5'd5;
      #1;
      checkOutput("aluOnlyReady", {31'd0, alu_ready}, 32'd1);
      checkOutput("aluOnlyHazardBefore", {31'd0, hazard}, 32'd0);
      pushExpected(5'd5, 32'h1234);
      tick();
      idle();
      #1;
      checkOutput("aluOnlyHazardInFlight", {31'd0, hazard}, 32'd1);
      tick();
      checkOutput("aluOnlyHazardCommitted", {31'd0, hazard}, 32'd0);
      ra1 = 5'd0;

      // Load return and ALU in the same cycle: load first, ALU via hold
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 1'b1, 32'hAA);
      #1;
      checkOutput("contentionAluReady", {31'd0, alu_ready}, 32'd1);
      pushExpected(5'd3, 32'hAA);
      pushExpected(5'd7, 32'hBB);
      tick();
      applyStimulus(1'b1, 5'd8, 32'hCC, 1'b0, 5'd0, 1'b0, 32'h0);
      ra1 = 5'd7;
      #1;
      checkOutput("holdFullAluReady", {31'd0, alu_ready}, 32'd0);
      checkOutput("holdHazard", {31'd0, hazard}, 32'd1);
      tick();
      idle();
      ra1 = 5'd0;
      tick();

      // WAW: ALU to a register with an outstanding load must wait for the load
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 1'b0, 32'h0);
      #1;
      checkOutput("wawBlocked", {31'd0, alu_ready}, 32'd0);
      tick();
      checkOutput("wawStillBlocked", {31'd0, alu_ready}, 32'd0);
      applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 1'b1, 32'h55);
      #1;
      checkOutput("wawBlockedOnReturn", {31'd0, alu_ready}, 32'd0);
      pushExpected(5'd9, 32'h55);
      tick();
      applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 1'b0, 32'h0);
      #1;
      checkOutput("wawReleased", {31'd0, alu_ready}, 32'd1);
      pushExpected(5'd9, 32'h99);
      tick();
      idle();
      tick();

      // Duplicate destination tags keep the register pending until the last return
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 32'h0);
      tick();
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h41);
      ra2 = 5'd4;
      pushExpected(5'd4, 32'h41);
      tick();
      idle();
      tick();
      checkOutput("dupStillPending", {31'd0, hazard}, 32'd1);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h42);
      pushExpected(5'd4, 32'h42);
      tick();
      idle();
      tick();
      checkOutput("dupCleared", {31'd0, hazard}, 32'd0);
      ra2 = 5'd0;

      // Fill the FIFO (one tag to x0), then push+pop at full
      begin
         logic [4:0] rds [4];
         rds = '{5'd10, 5'd0, 5'd11, 5'd12};
         for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, rds[i], 1'b0, 32'h0);
            #1;
            checkOutput($sformatf("fillReady%0d", i), {31'd0, ld_issue_ready}, 32'd1);
            tick();
         end
      end
      idle();
      #1;
      checkOutput("fullNotReady", {31'd0, ld_issue_ready}, 32'd0);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 1'b1, 32'h10);
      pushExpected(5'd10, 32'h10);
      #1;
      checkOutput("pushPopFullReady", {31'd0, ld_issue_ready}, 32'd0);
      tick();
      idle();
      #1;
      checkOutput("pushPopKeepsFull", {31'd0, ld_issue_ready}, 32'd0);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h20);
      tick();
      idle();
      #1;
      checkOutput("x0ReturnNoWrite", {31'd0, rf_we}, 32'd0);
      checkOutput("afterX0Ready", {31'd0, ld_issue_ready}, 32'd1);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h11);
      pushExpected(5'd11, 32'h11);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h12);
      pushExpected(5'd12, 32'h12);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h13);
      pushExpected(5'd13, 32'h13);
      tick();
      idle();
      tick();
      ra1 = 5'd13;
      #1;
      checkOutput("drainedHazard13", {31'd0, hazard}, 32'd0);
      checkOutput("drainedNoProtoErr", {31'd0, proto_err}, 32'd0);
      ra1 = 5'd0;

      // Protocol error on an empty FIFO, then asynchronous reset mid-stream
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h77);
      tick();
      idle();
      #1;
      checkOutput("protoErrSet", {31'd0, proto_err}, 32'd1);
      checkOutput("protoErrNoWrite", {31'd0, rf_we}, 32'd0);
      applyStimulus(1'b1, 5'd21, 32'h21, 1'b1, 5'd20, 1'b0, 32'h0);
      pushExpected(5'd21, 32'h21);
      tick();
      idle();
      ra1 = 5'd20;
      #1;
      checkOutput("preResetPending", {31'd0, hazard}, 32'd1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("asyncRstWe", {31'd0, rf_we}, 32'd0);
      checkOutput("asyncRstWa", {27'd0, rf_wa}, 32'd0);
      checkOutput("asyncRstWd", rf_wd, 32'd0);
      checkOutput("asyncRstProtoErr", {31'd0, proto_err}, 32'd0);
      checkOutput("asyncRstPending", {31'd0, hazard}, 32'd0);
      checkOutput("asyncRstIssueReady", {31'd0, ld_issue_ready}, 32'd1);
      tick();
      rst = 1'b0;
      ra1 = 5'd0;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h88);
      tick();
      idle();
      #1;
      checkOutput("lateReturnProtoErr", {31'd0, proto_err}, 32'd1);
      tick();
      tick();
      checkOutput("scoreboardDrain", expQ.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
